// File: rtl/score_bcd_display.sv
// BCD score accumulator with a digit-serial adder and registered seven-segment drive.
// Optional leading-zero blanking is enabled by defining SCORE_LEADING_ZERO_BLANK_EN.
module score_bcd_display #(
  parameter int DIGITS     = 6,
  parameter int ADD_DIGITS = 3
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    add_valid,
  output logic                    add_ready,
  input  logic [4*ADD_DIGITS-1:0] add_bcd,
  input  logic                    clear,
  output logic [4*DIGITS-1:0]     score_bcd,
  output logic [8*DIGITS-1:0]     hex_seg,
  output logic                    busy,
  output logic                    saturated
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Display contents for a zero score, which is also the post-reset image.
  function automatic logic [8*DIGITS-1:0] hex_reset_val();
    logic [8*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*8 +: 8] = (BLANK_EN && i > 0) ? 8'hFF : 8'hC0;
    end
    return r;
  endfunction

  localparam logic [8*DIGITS-1:0] HEX_RST = hex_reset_val();

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [4*DIGITS-1:0]   op_q, op_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic [4*DIGITS-1:0]   score_q, score_d;
  logic                  sat_q, sat_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [8*DIGITS-1:0]   hex_q, hex_d;
  logic [4*DIGITS-1:0]   op_clamped;
  logic [4:0]            digit_sum;

  // Operand digits beyond the award width are zero; out-of-range digits clamp to 9.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_op
      if (gi < ADD_DIGITS) begin : g_live
        assign op_clamped[gi*4 +: 4] =
          (add_bcd[gi*4 +: 4] > 4'd9) ? 4'd9 : add_bcd[gi*4 +: 4];
      end else begin : g_zero
        assign op_clamped[gi*4 +: 4] = 4'd0;
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
      if (BLANK_EN && gi > 0) begin : g_blank
        assign hex_d[gi*8 +: 8] = (|score_q[4*DIGITS-1:gi*4])
                                  ? seg_decode(score_q[gi*4 +: 4]) : 8'hFF;
      end else begin : g_plain
        assign hex_d[gi*8 +: 8] = seg_decode(score_q[gi*4 +: 4]);
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    op_d      = op_q;
    work_d    = work_q;
    score_d   = score_q;
    sat_d     = sat_q;
    digit_sum = {1'b0, score_q[int'(idx_q)*4 +: 4]}
              + {1'b0, op_q[int'(idx_q)*4 +: 4]}
              + {4'd0, carry_q};

    if (clear) begin
      state_d = S_IDLE;
      idx_d   = '0;
      carry_d = 1'b0;
      op_d    = '0;
      score_d = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (add_valid) begin
            op_d    = op_clamped;
            idx_d   = '0;
            carry_d = 1'b0;
            state_d = S_ADD;
          end
        end
        S_ADD: begin
          if (digit_sum > 5'd9) begin
            work_d[int'(idx_q)*4 +: 4] = 4'(digit_sum - 5'd10);
            carry_d = 1'b1;
          end else begin
            work_d[int'(idx_q)*4 +: 4] = digit_sum[3:0];
            carry_d = 1'b0;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_COMMIT: begin
          if (carry_q) begin
            score_d = ALL_NINES;
            sat_d   = 1'b1;
          end else begin
            score_d = work_q;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= '0;
      work_q  <= '0;
      score_q <= '0;
      sat_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      hex_q   <= HEX_RST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      work_q  <= work_d;
      score_q <= score_d;
      sat_q   <= sat_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      hex_q   <= hex_d;
    end
  end

  assign add_ready = ready_q;
  assign busy      = busy_q;
  assign score_bcd = score_q;
  assign saturated = sat_q;
  assign hex_seg   = hex_q;

endmodule

// File: doc/score_bcd_display.md
# score_bcd_display

Parametrised BCD score accumulator and seven-segment driver for the game's HEX display bank. Game logic submits point awards through a valid/ready handshake. The block adds each award into an N-digit packed-BCD score one digit per cycle, saturates at all nines and drives registered, active-low segment patterns for every digit. It sits between the game-state logic and the board HEX outputs, replacing fixed per-digit hex decoders.

## Interface
- DIGITS, 6: score width in BCD digits (1..8)
- ADD_DIGITS, 3: award width in BCD digits (1..DIGITS)
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- add_valid  in  1  award present on add_bcd
- add_ready  out  1  block can accept an award
- add_bcd  in  4*ADD_DIGITS  award, packed BCD, digit 0 in bits [3:0]
- clear  in  1  synchronous score clear
- score_bcd  out  4*DIGITS  committed score, packed BCD
- hex_seg  out  8*DIGITS  segments per digit, active-low; within each byte bit0=a..bit6=g, bit7=dp
- busy  out  1  addition in progress
- saturated  out  1  sticky overflow flag

## Operation
- States:
  - IDLE: add_ready=1, busy=0.
  - ADD: add_ready=0, busy=1.
  - COMMIT: add_ready=0, busy=1.
- An award is accepted on a rising edge with add_valid=1, add_ready=1 and clear=0.
  - add_bcd latches into the operand register.
  - Operand digits at index ADD_DIGITS and above are zero.
  - Digit index = 0, carry = 0, next state ADD.
- Operand digits >9 are clamped to 9 at latch time.
- ADD, each edge: work[idx] = score[idx] + op[idx] + carry.
  - If the sum is >9: subtract 10 and set carry = 1. Otherwise carry = 0.
  - idx increments. After idx = DIGITS-1, go to COMMIT.
- COMMIT edge: write score_bcd.
  - carry=0: score_bcd = work.
  - carry=1: score_bcd = all 9s and saturated = 1.
  - Return to IDLE.
- A saturated score stays all 9s. Further awards are accepted and complete normally, but the score does not change.
- clear=1, any state:
  - Next edge: score_bcd=0, saturated=0, state=IDLE, operand and carry discarded.
  - clear has priority over an accept and over an in-flight addition.
- hex_seg is the registered decode of score_bcd. Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. dp is always off (bit7=1).
- Outputs at reset:
  - score_bcd=0, saturated=0, busy=0, add_ready=1, state IDLE.
  - hex_seg per Configuration: digit 0 = C0; other digits = FF with blanking, C0 without.

## Timing
- Accept on edge E0.
- ADD occupies edges E1..E_DIGITS.
- COMMIT on E_DIGITS+1. score_bcd and saturated update there, and add_ready rises after that edge.
- hex_seg reflects the new score on E_DIGITS+2.
- Throughput: one award per DIGITS+2 cycles. Back-to-back add_valid is held off by add_ready=0.
- clear: score_bcd=0 after 1 edge, hex_seg updated after 2 edges. add_ready=1 after the clear edge.
- Reset_n low forces reset values immediately, regardless of clock. Deassertion mid-frame resumes in IDLE.
- add_bcd and add_valid are sampled only on the accept edge. Changes during ADD are ignored.

## Configuration
- SCORE_LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit drive FF (blank). Digit 0 always displays. Blanking is evaluated on the same registered decode, so it adds no latency.
- Not defined: all DIGITS positions always display their value, leading zeros included.

## Test plan
- Reset: pulse Reset_n low mid-addition -> score_bcd=000000, busy=0, add_ready=1, saturated=0. hex_seg = FF FF FF FF FF C0 with the macro, C0×6 without.
- Single award, DIGITS=6: add 0x123 to 0 ->
  - add_ready=0 for 7 cycles
  - score_bcd=0x000123 at E7
  - hex_seg digits 0..2 = B0, A4, F9 at E8
- Carry chain: score 0x000999 + 0x001 -> 0x001000, saturated=0.
- Saturation: score 0x999999 + 0x001 -> 0x999999, saturated=1. A further award of 0x500 -> score unchanged, saturated still 1.
- Clear priority:
  - Assert clear during the third ADD cycle of 0x050 onto 0x000200 -> score_bcd=0 next edge, no commit afterwards, add_ready=1.
  - clear together with add_valid in IDLE -> award dropped.
- Clamp: add 0x00F onto 0 -> score_bcd=0x000009.
